// File: rtl/anc_pkg.sv
// anc_pkg: shared types and helpers for the noise-cancellation output stage.
//   sample_t      - signed 16-bit audio sample
//   SAMPLE_MAX/MIN - clamp limits of sample_t
//   mixer_state_t - anc_mixer sequencing states
//   sat16()       - clamps a 17-bit difference into sample_t and flags the clamp
package anc_pkg;

  typedef logic signed [15:0] sample_t;

  localparam sample_t SAMPLE_MAX = 16'sh7FFF;
  localparam sample_t SAMPLE_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ANTI,
    MIX
  } mixer_state_t;

  typedef struct packed {
    sample_t value;
    logic    clamped;
  } sat_result_t;

  // A 17-bit difference of two 16-bit samples fits in 16 bits exactly when
  // its top two bits agree; otherwise the sign bit tells which rail to use.
  function automatic sat_result_t sat16(input logic signed [16:0] d);
    sat_result_t r;
    r.clamped = d[16] ^ d[15];
    if (!r.clamped) r.value = d[15:0];
    else if (d[16]) r.value = SAMPLE_MIN;
    else            r.value = SAMPLE_MAX;
    return r;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous FIFO of sample_t words.
//   clk, rst_n - clock, asynchronous active-low reset
//   push/push_data - write request and data; ignored when full unless a pop
//                    happens in the same cycle
//   pop        - read request; ignored when empty
//   head       - oldest entry (0 when empty)
//   full/empty - occupancy status
module sample_fifo
  import anc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  sample_t push_data,
  input  logic    pop,
  output sample_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  sample_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop frees the slot the push needs, so a full FIFO still accepts it.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only read after it
  // has been written, and head is forced to 0 while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/anc_mixer.sv
// anc_mixer: residual = sat(mic - anti) for each mic sample, buffered to a
// valid/ready consumer, with windowed mean-square error and sticky faults.
//   clk_in, rst_n_in        - clock, asynchronous active-low reset
//   mic_ready_in/mic_in     - primary-mic strobe and sample
//   anti_done_in/anti_in    - anti-noise strobe and sample
//   enable_in               - 0 = bypass (anti treated as 0)
//   clear_flags_in          - clears sticky flags and sat_count_out
//   out_valid_out/out_data_out/out_ready_in - residual stream
//   err_energy_out/err_energy_valid_out     - mean residual^2 per window
//   sat_count_out           - clamp events, saturating
//   timeout_out/mic_overrun_out/fifo_overflow_out - sticky fault flags
module anc_mixer
  import anc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255,
  parameter int WIN_LOG2   = 10
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        mic_ready_in,
  input  logic [15:0] mic_in,
  input  logic        anti_done_in,
  input  logic [15:0] anti_in,
  input  logic        enable_in,
  input  logic        clear_flags_in,
  output logic        out_valid_out,
  output logic [15:0] out_data_out,
  input  logic        out_ready_in,
  output logic [31:0] err_energy_out,
  output logic        err_energy_valid_out,
  output logic [15:0] sat_count_out,
  output logic        timeout_out,
  output logic        mic_overrun_out,
  output logic        fifo_overflow_out
);

  localparam int CW    = $clog2(TIMEOUT + 1);
  localparam int ACC_W = 31 + WIN_LOG2;

  mixer_state_t        state_q, state_d;
  sample_t             mic_q, anti_q;
  logic [CW-1:0]       wait_cnt_q;

  logic                in_mix;
  logic                timeout_evt, overrun_evt, overflow_evt, sat_evt;
  logic signed [16:0]  diff;
  sat_result_t         mix_sat;
  logic [15:0]         res_mag;
  logic [30:0]         sq;
  logic [ACC_W-1:0]    acc_q, acc_sum;
  logic [WIN_LOG2-1:0] win_cnt_q;
  logic                win_close;
  sample_t             fifo_head;
  logic                fifo_full, fifo_empty;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    timeout_evt = 1'b0;
    case (state_q)
      IDLE:      if (mic_ready_in) state_d = enable_in ? WAIT_ANTI : MIX;
      WAIT_ANTI: begin
        if (anti_done_in) begin
          state_d = MIX;
        end else if (wait_cnt_q == CW'(TIMEOUT)) begin
          state_d     = MIX;
          timeout_evt = 1'b1;
        end
      end
      MIX:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // anti_q is zeroed at capture so bypass and timeout both mix against 0.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mic_q      <= '0;
      anti_q     <= '0;
      wait_cnt_q <= '0;
    end else begin
      if (state_q == IDLE && mic_ready_in) begin
        mic_q      <= mic_in;
        anti_q     <= '0;
        wait_cnt_q <= '0;
      end
      if (state_q == WAIT_ANTI) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
        if (anti_done_in) anti_q <= anti_in;
      end
    end
  end

  assign in_mix      = (state_q == MIX);
  assign overrun_evt = mic_ready_in && (state_q != IDLE);
  assign diff        = {mic_q[15], mic_q} - {anti_q[15], anti_q};
  assign mix_sat     = sat16(diff);
  assign sat_evt     = in_mix && mix_sat.clamped;

  // |res| fits in 16 unsigned bits (|-32768| = 0x8000), so the square is
  // formed on magnitudes and never needs more than 31 bits.
  assign res_mag   = mix_sat.value[15] ? (~mix_sat.value + 16'd1) : mix_sat.value;
  assign sq        = {15'd0, res_mag} * {15'd0, res_mag};
  assign acc_sum   = acc_q + ACC_W'(sq);
  assign win_close = &win_cnt_q;

  // When full the FIFO is non-empty, so a ready consumer always frees a slot.
  assign overflow_evt = in_mix && fifo_full && !out_ready_in;

  sample_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_in),
    .rst_n    (rst_n_in),
    .push     (in_mix),
    .push_data(mix_sat.value),
    .pop      (out_ready_in),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign out_valid_out = !fifo_empty;
  assign out_data_out  = fifo_head;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      acc_q                <= '0;
      win_cnt_q            <= '0;
      err_energy_out       <= '0;
      err_energy_valid_out <= 1'b0;
      sat_count_out        <= '0;
      timeout_out          <= 1'b0;
      mic_overrun_out      <= 1'b0;
      fifo_overflow_out    <= 1'b0;
    end else begin
      err_energy_valid_out <= in_mix && win_close;
      if (in_mix) begin
        win_cnt_q <= win_cnt_q + 1'b1;
        if (win_close) begin
          // Closing sample belongs to this window; the next one starts empty.
          err_energy_out <= {1'b0, acc_sum[ACC_W-1:WIN_LOG2]};
          acc_q          <= '0;
        end else begin
          acc_q <= acc_sum;
        end
      end

      // A clamp in the clearing cycle is counted after the clear.
      if (clear_flags_in)
        sat_count_out <= sat_evt ? 16'd1 : 16'd0;
      else if (sat_evt && sat_count_out != 16'hFFFF)
        sat_count_out <= sat_count_out + 1'b1;

      timeout_out       <= timeout_evt  | (timeout_out       & ~clear_flags_in);
      mic_overrun_out   <= overrun_evt  | (mic_overrun_out   & ~clear_flags_in);
      fifo_overflow_out <= overflow_evt | (fifo_overflow_out & ~clear_flags_in);
    end
  end

endmodule

// File: tb/tb_anc_mixer.sv
// tb_anc_mixer: directed stimulus for anc_mixer with a timestamp-based
// transaction model checked every cycle, plus literal expectations.
module tb_anc_mixer;

  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 255;
  localparam int WIN_LOG2   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mic_ready = 1'b0;
  logic [15:0] mic = '0;
  logic        anti_done = 1'b0;
  logic [15:0] anti = '0;
  logic        enable = 1'b0;
  logic        clear_flags = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready = 1'b1;
  logic [31:0] err_energy;
  logic        err_energy_valid;
  logic [15:0] sat_count;
  logic        timeout_flag, overrun_flag, overflow_flag;

  anc_mixer #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .TIMEOUT   (TIMEOUT),
    .WIN_LOG2  (WIN_LOG2)
  ) dut (
    .clk_in              (clk),
    .rst_n_in            (rst_n),
    .mic_ready_in        (mic_ready),
    .mic_in              (mic),
    .anti_done_in        (anti_done),
    .anti_in             (anti),
    .enable_in           (enable),
    .clear_flags_in      (clear_flags),
    .out_valid_out       (out_valid),
    .out_data_out        (out_data),
    .out_ready_in        (out_ready),
    .err_energy_out      (err_energy),
    .err_energy_valid_out(err_energy_valid),
    .sat_count_out       (sat_count),
    .timeout_out         (timeout_flag),
    .mic_overrun_out     (overrun_flag),
    .fifo_overflow_out   (overflow_flag)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  // A captured mic sample waits from cycle m_wait_start; its mix is scheduled
  // for the cycle after the anti sample arrives or the wait budget runs out.
  int     cyc = 0;
  bit     m_have = 0, m_wait = 0;
  int     m_wait_start = 0, m_mix_at = 0;
  int     m_mic = 0, m_anti = 0;
  int     q[$];
  longint m_sum = 0;
  int     m_n = 0;
  longint exp_energy = 0;
  bit     exp_ev = 0;
  int     exp_sat = 0;
  bit     exp_to = 0, exp_ovr = 0, exp_ovf = 0;

  task automatic model_step();
    bit busy, mixing, pop, full, sat, set_to, set_ovr, set_ovf;
    int diff, res;
    if (!rst_n) begin
      m_have = 0; m_wait = 0; q.delete();
      m_sum = 0; m_n = 0; exp_energy = 0; exp_ev = 0;
      exp_sat = 0; exp_to = 0; exp_ovr = 0; exp_ovf = 0;
      return;
    end
    busy   = m_have;
    mixing = m_have && !m_wait && (m_mix_at == cyc);
    pop    = (q.size() > 0) && out_ready;
    full   = (q.size() == FIFO_DEPTH);
    sat = 0; set_to = 0; set_ovr = 0; set_ovf = 0; exp_ev = 0;
    if (m_have && m_wait) begin
      if (anti_done) begin
        m_anti = $signed(anti); m_wait = 0; m_mix_at = cyc + 1;
      end else if (cyc - m_wait_start == TIMEOUT) begin
        m_anti = 0; m_wait = 0; m_mix_at = cyc + 1; set_to = 1;
      end
    end
    if (pop) void'(q.pop_front());
    if (mixing) begin
      diff = m_mic - m_anti;
      res  = diff;
      if (diff > 32767)       begin res = 32767;  sat = 1; end
      else if (diff < -32768) begin res = -32768; sat = 1; end
      if (full && !pop) set_ovf = 1;
      else              q.push_back(res);
      m_sum += longint'(res) * longint'(res);
      m_n++;
      if (m_n == (1 << WIN_LOG2)) begin
        exp_energy = m_sum >>> WIN_LOG2;
        exp_ev = 1; m_sum = 0; m_n = 0;
      end
      m_have = 0;
    end
    if (mic_ready) begin
      if (busy) set_ovr = 1;
      else begin
        m_have = 1; m_mic = $signed(mic); m_anti = 0;
        if (enable) begin m_wait = 1; m_wait_start = cyc + 1; end
        else        begin m_wait = 0; m_mix_at = cyc + 1; end
      end
    end
    if (clear_flags) exp_sat = sat ? 1 : 0;
    else if (sat && exp_sat < 65535) exp_sat++;
    exp_to  = set_to  | (exp_to  & !clear_flags);
    exp_ovr = set_ovr | (exp_ovr & !clear_flags);
    exp_ovf = set_ovf | (exp_ovf & !clear_flags);
    cyc++;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    check("cyc_valid", out_valid, q.size() > 0);
    if (q.size() > 0 && out_valid) check("cyc_data", $signed(out_data), q[0]);
    check("cyc_ev", err_energy_valid, exp_ev);
    check("cyc_energy", err_energy, exp_energy);
    check("cyc_sat", sat_count, exp_sat);
    check("cyc_timeout", timeout_flag, exp_to);
    check("cyc_overrun", overrun_flag, exp_ovr);
    check("cyc_overflow", overflow_flag, exp_ovf);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mic_strobe(input int v, input bit en);
    mic = 16'(v); enable = en; mic_ready = 1'b1;
    tick();
    mic_ready = 1'b0;
  endtask

  task automatic anti_strobe(input int v);
    anti = 16'(v); anti_done = 1'b1;
    tick();
    anti_done = 1'b0;
  endtask

  // Mic, then anti 'gap'+1 cycles later; result must appear 2 cycles after anti.
  task automatic run_sample(input string name, input int m, input int a,
                            input int gap, input int exp);
    mic_strobe(m, 1'b1);
    tick(gap);
    anti_strobe(a);
    @(negedge clk);
    check({name, "_early"}, out_valid, 0);
    tick();
    @(negedge clk);
    check({name, "_valid"}, out_valid, 1);
    check({name, "_data"}, $signed(out_data), exp);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_valid"}, out_valid, 0);
    check({name, "_data"}, out_data, 0);
    check({name, "_energy"}, err_energy, 0);
    check({name, "_ev"}, err_energy_valid, 0);
    check({name, "_sat"}, sat_count, 0);
    check({name, "_to"}, timeout_flag, 0);
    check({name, "_ovr"}, overrun_flag, 0);
    check({name, "_ovf"}, overflow_flag, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t, want < 200000", $time);
    $fatal(1);
  end

  int drain_exp[4] = '{2, 3, 4, 6};

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Basic subtraction, anti 40 cycles after mic.
    run_sample("basic", 1000, 300, 39, 700);
    check("basic_sat", sat_count, 0);
    check("basic_flags", {timeout_flag, overrun_flag, overflow_flag}, 0);

    // Saturation at both rails.
    tick();
    run_sample("sat_hi", 30000, -10000, 3, 32767);
    check("sat_hi_count", sat_count, 1);
    tick();
    run_sample("sat_lo", -32768, 1, 3, -32768);
    check("sat_lo_count", sat_count, 2);

    // Timeout: mix lands TIMEOUT+1 cycles after WAIT_ANTI entry.
    tick();
    mic_strobe(1234, 1'b1);
    tick(TIMEOUT + 1);
    @(negedge clk);
    check("to_early", out_valid, 0);
    tick();
    @(negedge clk);
    check("to_valid", out_valid, 1);
    check("to_data", $signed(out_data), 1234);
    check("to_flag", timeout_flag, 1);
    tick();
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    @(negedge clk);
    check("clr_to", timeout_flag, 0);
    check("clr_sat", sat_count, 0);

    // FIFO backpressure: 1..4 fill, 5 dropped, 6 pushed alongside a pop.
    tick();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      mic_strobe(i, 1'b0);
      tick();
    end
    @(negedge clk);
    check("ovf_flag", overflow_flag, 1);
    mic_strobe(6, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    check("drain_0", $signed(out_data), 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_valid", out_valid, 1);
      check("drain_data", $signed(out_data), drain_exp[i]);
      tick();
    end
    @(negedge clk);
    check("drain_empty", out_valid, 0);
    check("ovf_kept", overflow_flag, 1);

    // Reset to align the energy window.
    tick();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick();

    // Energy window: 2,-2,4,0 -> (4+4+16+0)/4 = 6.
    mic_strobe(2, 1'b0);  tick();
    mic_strobe(-2, 1'b0); tick();
    mic_strobe(4, 1'b0);  tick();
    mic_strobe(0, 1'b0);
    @(negedge clk);
    check("win1_pre", err_energy_valid, 0);
    tick();
    @(negedge clk);
    check("win1_ev", err_energy_valid, 1);
    check("win1_energy", err_energy, 6);
    tick();
    @(negedge clk);
    check("win1_single", err_energy_valid, 0);
    // Next window starts from 0: 1,1,1,1 -> 1.
    tick();
    for (int i = 0; i < 3; i++) begin
      mic_strobe(1, 1'b0);
      tick();
    end
    mic_strobe(1, 1'b0);
    tick();
    @(negedge clk);
    check("win2_ev", err_energy_valid, 1);
    check("win2_energy", err_energy, 1);

    // Overrun: second strobe while waiting is dropped, first still completes.
    tick();
    mic_strobe(500, 1'b1);
    tick(4);
    mic_strobe(999, 1'b1);
    tick(2);
    anti_strobe(100);
    tick();
    @(negedge clk);
    check("ovr_flag", overrun_flag, 1);
    check("ovr_data", $signed(out_data), 400);

    // Reset mid-wait: outputs clear at once, pending sample is discarded.
    tick();
    mic_strobe(777, 1'b1);
    tick(10);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    tick(2);
    rst_n = 1'b1;
    tick();
    anti_strobe(5);
    tick(TIMEOUT + 5);
    @(negedge clk);
    check("rst_no_out", out_valid, 0);
    check("rst_no_to", timeout_flag, 0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/anc_mixer.md
# anc_mixer

Output stage of the noise-cancellation path; sits directly downstream of `delay_and_scale`. For each primary-mic sample it waits for the matching anti-noise sample (`done_out`/`signal_out` of `delay_and_scale`), computes the saturated residual `mic - anti` and buffers it in a small FIFO. The FIFO drains to the DAC/PWM consumer over a valid/ready handshake. It also reports windowed mean error energy and sticky fault flags so that the delay/scale settings can be tuned.

## Interface
- `FIFO_DEPTH`, 4: output FIFO entries (power of two, ≥2).
- `TIMEOUT`, 255: maximum cycles to wait for the anti-noise sample after a mic strobe.
- `WIN_LOG2`, 10: energy window is 2^WIN_LOG2 residual samples.

Ports:
- `clk_in` in 1: system clock; single clock domain.
- `rst_n_in` in 1: reset, asynchronous, active-low.
- `mic_ready_in` in 1: one-cycle strobe; `mic_in` is valid. This is the same strobe that drives `delay_and_scale.ready_in`.
- `mic_in` in 16: signed primary-mic sample.
- `anti_done_in` in 1: one-cycle strobe from `delay_and_scale.done_out`.
- `anti_in` in 16: signed anti-noise sample from `delay_and_scale.signal_out`.
- `enable_in` in 1: 0 selects bypass (residual = mic); sampled on `mic_ready_in`.
- `clear_flags_in` in 1: synchronous clear of sticky flags and `sat_count_out`.
- `out_valid_out` out 1: FIFO head valid.
- `out_data_out` out 16: signed residual at FIFO head.
- `out_ready_in` in 1: consumer accepts head.
- `err_energy_out` out 32: unsigned mean of residual² over the last window.
- `err_energy_valid_out` out 1: one-cycle pulse when `err_energy_out` updates.
- `sat_count_out` out 16: saturation events, saturating at 65535.
- `timeout_out` out 1: sticky; an anti sample missed `TIMEOUT`.
- `mic_overrun_out` out 1: sticky; a mic strobe was dropped.
- `fifo_overflow_out` out 1: sticky; a residual was dropped because the FIFO was full.

## Operation
- FSM states: IDLE, WAIT_ANTI, MIX.
  - IDLE: on `mic_ready_in`, register `mic_in` and `enable_in`. Go to WAIT_ANTI if enabled; otherwise go to MIX with anti=0.
  - WAIT_ANTI: wait counter starts at 0 and increments each cycle.
    - On `anti_done_in`, register `anti_in` and go to MIX.
    - If the counter reaches `TIMEOUT` without `anti_done_in`, set anti=0, set `timeout_out`, and go to MIX.
    - If `anti_done_in` and timeout occur in the same cycle, `anti_done_in` wins.
  - MIX (one cycle): compute residual, push it to the FIFO, update energy and saturation stats, return to IDLE.
- `anti_done_in` in IDLE or MIX is ignored.
- `mic_ready_in` in WAIT_ANTI or MIX is dropped and sets `mic_overrun_out`.
- Arithmetic:
  - 17-bit `diff = mic - anti`.
  - Clamp to [-32768, 32767]; each clamp increments `sat_count_out` (saturating at 65535).
  - `sq = res*res` is 31-bit unsigned.
  - Accumulator is `31+WIN_LOG2` bits.
- Energy window:
  - A window closes on the 2^WIN_LOG2-th MIX.
  - At close, `err_energy_out = acc >> WIN_LOG2` (zero-extended to 32 bits) and `err_energy_valid_out` pulses.
  - The accumulator restarts with the closing sample excluded, so windows do not overlap.
- FIFO:
  - Push when full: the new residual is dropped and `fifo_overflow_out` is set.
  - Push and pop in the same cycle while full: both occur, no drop.
  - `out_data_out` holds while `out_valid_out && !out_ready_in`.
- `clear_flags_in` clears `timeout_out`, `mic_overrun_out`, `fifo_overflow_out` and `sat_count_out`. If a set event occurs in the same cycle, the set wins.
- Reset value of every output is 0; FSM returns to IDLE; FIFO empties; window counter and accumulator are cleared.
- Reset mid-WAIT_ANTI discards the pending sample.

## Timing
- A mic strobe registered at edge t enters WAIT_ANTI at t+1.
- `anti_done_in` high in cycle k: MIX in cycle k+1; FIFO written at the end of k+1; `out_valid_out` high in k+2 if the FIFO was empty.
- Bypass: `out_valid_out` is high 2 cycles after the mic strobe.
- Timeout: with no anti sample, MIX occurs `TIMEOUT`+1 cycles after WAIT_ANTI entry.
- `err_energy_valid_out` pulses in the cycle after the closing MIX.
- At the nominal 128-cycle sample spacing, no overrun is possible when `delay_and_scale` latency is below 126 cycles.

## Structure
- Package `anc_pkg` holds:
  - `sample_t` (signed 16);
  - `SAMPLE_MAX`/`SAMPLE_MIN`;
  - the `mixer_state_t` enum;
  - a `sat16` function (17-bit to `sample_t`, plus clamp flag).
- Sub-module `sample_fifo`: parameterized synchronous FIFO (`DEPTH`, `sample_t`) with push/pop/full/empty and simultaneous push-pop when full.
- Everything else lives in `anc_mixer`.

## Test plan
- Basic subtraction: `mic_in=1000`; `anti_in=300` with `anti_done_in` 40 cycles later -> `out_data_out=700`, `out_valid_out` high 2 cycles after `anti_done_in`, no flags set.
- Saturation:
  - mic=30000, anti=-10000 -> 32767, `sat_count_out=1`;
  - then mic=-32768, anti=1 -> -32768, `sat_count_out=2`.
- Timeout: mic=1234 and no `anti_done_in` -> output 1234 after `TIMEOUT`+1 cycles, `timeout_out=1`; `clear_flags_in` -> 0.
- FIFO backpressure: `out_ready_in=0`, six samples (residuals 1..6) -> residual 5 is dropped and `fifo_overflow_out=1`. Residual 6 is pushed in the same cycle as a pop, so it is not dropped. Draining yields 1,2,3,4,6 in order.
- Energy with `WIN_LOG2=2`: residuals 2,-2,4,0 -> `err_energy_out=6`, a single `err_energy_valid_out` pulse; the next window starts from 0.
- Overrun and reset: a second mic strobe during WAIT_ANTI -> `mic_overrun_out=1`, first sample still completes. Asserting `rst_n_in` low mid-WAIT_ANTI -> all outputs 0 immediately and no residual emitted.
